mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning address width.
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports IFReq in 1 (fetch request), IFAddr in ADDR_WIDTH (fetch address).
REQ-006 SHALL have ports IFData out DATA_WIDTH (fetched word) and IFDone out 1 (fetch complete).
REQ-007 SHALL have ports MemReadM in 1, MemWriteM in 1, AddrM in ADDR_WIDTH, WriteDataM in DATA_WIDTH, AddrModeM in 1 (byte access).
REQ-008 SHALL have ports ReadDataM out DATA_WIDTH and MDone out 1 (data access complete).
REQ-009 SHALL have ports StallF out 1 and StallM out 1, both pipeline stall requests.
REQ-010 SHALL have memory-side ports mem_req out 1, mem_we out 1, mem_addr out ADDR_WIDTH, mem_wdata out DATA_WIDTH, mem_byte out 1, mem_rdata in DATA_WIDTH, mem_ack in 1.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY_IF, BUSY_D, DONE.
REQ-012 In IDLE, any request SHALL be granted at the next edge: latch addr/wdata/we/byte/owner and enter BUSY_IF or BUSY_D.
REQ-013 Data request SHALL be MemReadM|MemWriteM; mem_we SHALL equal latched MemWriteM.
REQ-014 mem_req SHALL be high only in BUSY_IF/BUSY_D, driven from registers, with mem_addr/mem_wdata/mem_we/mem_byte held stable until mem_ack.
REQ-015 On edge with mem_ack=1 in BUSY_x: capture mem_rdata into owner's data register (reads only) and enter DONE.
REQ-016 In DONE, exactly one of IFDone/MDone (owner's) SHALL be high for one cycle; no new grant in DONE; next state IDLE.
REQ-017 Minimum latency: request seen in IDLE at edge N, mem_req high from N, ack at N+1 earliest, Done high in cycle after N+1 edge (3 cycles request-to-done with zero-wait memory).
REQ-018 StallF SHALL equal IFReq & ~IFDone; StallM SHALL equal data request & ~MDone (combinational).
REQ-019 IFData/ReadDataM SHALL hold their last captured value until the next completion for that owner.
REQ-020 mem_ack outside BUSY_x SHALL be ignored.
REQ-021 Simultaneous IF and data requests in IDLE SHALL be resolved per REQ-026/027; loser stays stalled until served.

Reset
REQ-022 rst SHALL force IDLE immediately, asynchronously, regardless of state.
REQ-023 Reset values: mem_req=0, mem_we=0, mem_byte=0, mem_addr=0, mem_wdata=0, IFDone=0, MDone=0, IFData=0, ReadDataM=0, round-robin pointer=IF-last.
REQ-024 Reset mid-transaction SHALL abandon it: no Done pulse, no data capture; a late mem_ack after reset SHALL be ignored.

Configuration
REQ-025 Macro MEMARB_ROUND_ROBIN_EN SHALL select tie-break policy.
REQ-026 Without it: fixed priority, data request always wins ties.
REQ-027 With it: 1-bit last-grant pointer updated on every grant; on tie the requester not granted last wins; after reset data wins first tie.

Verification
REQ-028 Fetch only, IFAddr=0x100, mem_ack one cycle after mem_req, mem_rdata=0x00500093 -> mem_addr=0x100, mem_we=0; IFDone one-cycle pulse; IFData=0x00500093; StallF low after pulse.
REQ-029 Store MemWriteM=1, AddrM=0x2000, WriteDataM=0xDEADBEEF, AddrModeM=1, mem_ack after 3 wait cycles -> mem_we=1, mem_byte=1, fields stable all 4 cycles; MDone pulse; ReadDataM unchanged.
REQ-030 IFReq and MemReadM both high from reset, default build -> data served first, then fetch; StallF high throughout both transactions.
REQ-031 Same stimulus held for four grants with MEMARB_ROUND_ROBIN_EN -> grant order D, IF, D, IF.
REQ-032 rst pulsed while BUSY_D, then mem_ack asserted -> state IDLE, mem_req=0, no MDone, ReadDataM=0.
REQ-033 mem_ack held high while IDLE with no requests -> no Done pulse, no state change.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between an instruction-fetch requester (IF) and a
// data-access requester (D). One transaction is in flight at a time:
//   IDLE -> BUSY_IF/BUSY_D -> DONE -> IDLE
// Optional feature macro: MEMARB_ROUND_ROBIN_EN
//   undefined : on a tie the data request always wins
//   defined   : on a tie the requester not granted last wins (data wins the
//               first tie after reset)
//
// Memory handshake: mem_req is a registered request. mem_addr, mem_wdata,
// mem_we and mem_byte are loaded together with mem_req and held unchanged
// until the memory returns mem_ack=1. The transfer completes on the first
// rising edge where mem_req=1 and mem_ack=1. mem_ack is ignored whenever no
// request is outstanding.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // fetch port
  input  logic                  IFReq,
  input  logic [ADDR_WIDTH-1:0] IFAddr,
  output logic [DATA_WIDTH-1:0] IFData,
  output logic                  IFDone,
  // data port
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [ADDR_WIDTH-1:0] AddrM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic                  AddrModeM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  MDone,
  // pipeline stalls
  output logic                  StallF,
  output logic                  StallM,
  // memory side
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_byte,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  // FSM state, for observation only
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_IF = 2'd1;
  localparam logic [1:0] BUSY_D  = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0] state;
  logic       dreq;
  logic       any_req;
  logic       grant_d;

  assign dreq    = MemReadM | MemWriteM;
  assign any_req = dreq | IFReq;

`ifdef MEMARB_ROUND_ROBIN_EN
  // 1 = data was granted last; reset value means "IF last" so data wins first tie
  logic last_d;

  // Tie-break: data wins unless it was also the last one granted
  always_comb begin
    grant_d = dreq & (~IFReq | ~last_d);
  end

  // Remember the owner of every grant for the next tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (state == IDLE && any_req) begin
      last_d <= grant_d;
    end
  end
`else
  // Tie-break: fixed priority, data always wins
  always_comb begin
    grant_d = dreq;
  end
`endif

  // Arbitration FSM: grant in IDLE, wait for ack, one-cycle done, back to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      IFDone <= 1'b0;
      MDone  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state <= grant_d ? BUSY_D : BUSY_IF;
          end
        end
        BUSY_IF: begin
          if (mem_ack) begin
            IFDone <= 1'b1;
            state  <= DONE;
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            MDone <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          // DONE: the done pulse lasts exactly this one cycle, no new grant
          IFDone <= 1'b0;
          MDone  <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Memory request registers: loaded at grant, held until ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_byte  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (state == IDLE && any_req) begin
      mem_req   <= 1'b1;
      mem_we    <= grant_d & MemWriteM;
      mem_byte  <= grant_d & AddrModeM;
      mem_addr  <= grant_d ? AddrM : IFAddr;
      mem_wdata <= grant_d ? WriteDataM : '0;
    end else if ((state == BUSY_IF || state == BUSY_D) && mem_ack) begin
      mem_req <= 1'b0;
    end
  end

  // Read-data capture: only on a completing read, held until the owner's next one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      IFData    <= '0;
      ReadDataM <= '0;
    end else if (mem_ack) begin
      if (state == BUSY_IF) begin
        IFData <= mem_rdata;
      end else if (state == BUSY_D && !mem_we) begin
        ReadDataM <= mem_rdata;
      end
    end
  end

  assign StallF    = IFReq & ~IFDone;
  assign StallM    = dreq & ~MDone;
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter: a table of single transactions
// (fetch/load/store with varying memory wait states), then hand-written
// sequences for reset mid-transaction, stray acks and simultaneous requests.
// Honours MEMARB_ROUND_ROBIN_EN for the tie-order expectations.
module tb_mem_port_arbiter;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY_IF = 2'd1;
  localparam logic [1:0] S_BUSY_D  = 2'd2;

  logic        clk;
  logic        rst;
  logic        IFReq;
  logic [31:0] IFAddr;
  logic [31:0] IFData;
  logic        IFDone;
  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] AddrM;
  logic [31:0] WriteDataM;
  logic        AddrModeM;
  logic [31:0] ReadDataM;
  logic        MDone;
  logic        StallF;
  logic        StallM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_byte;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .IFReq(IFReq), .IFAddr(IFAddr), .IFData(IFData), .IFDone(IFDone),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .AddrM(AddrM),
    .WriteDataM(WriteDataM), .AddrModeM(AddrModeM),
    .ReadDataM(ReadDataM), .MDone(MDone),
    .StallF(StallF), .StallM(StallM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte(mem_byte),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic        we;
    logic        bsel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_if;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    IFReq = 0; IFAddr = 0; MemReadM = 0; MemWriteM = 0; AddrM = 0;
    WriteDataM = 0; AddrModeM = 0; mem_rdata = 0; mem_ack = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  // Drive one transaction from IDLE and check it cycle by cycle
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    if (v.is_d) begin
      MemReadM = ~v.we; MemWriteM = v.we; AddrM = v.addr;
      WriteDataM = v.wdata; AddrModeM = v.bsel;
    end else begin
      IFReq = 1; IFAddr = v.addr;
    end
    @(negedge clk);
    check("grant_state", {30'd0, dbg_state}, {30'd0, v.is_d ? S_BUSY_D : S_BUSY_IF});
    check("stall_busy", {31'd0, v.is_d ? StallM : StallF}, 32'd1);
    for (int c = 0; c <= v.waits; c++) begin
      if (c > 0) @(negedge clk);
      check("mem_req_busy", {31'd0, mem_req}, 32'd1);
      check("mem_addr", mem_addr, v.addr);
      check("mem_we", {31'd0, mem_we}, {31'd0, v.is_d & v.we});
      check("mem_byte", {31'd0, mem_byte}, {31'd0, v.is_d & v.bsel});
      if (v.is_d && v.we) check("mem_wdata", mem_wdata, v.wdata);
      if (c == v.waits) begin
        mem_ack = 1; mem_rdata = v.rdata;
      end else begin
        mem_rdata = 32'h5A5A5A5A;
      end
    end
    @(negedge clk);
    check("ifdone_pulse", {31'd0, IFDone}, {31'd0, ~v.is_d});
    check("mdone_pulse", {31'd0, MDone}, {31'd0, v.is_d});
    check("mem_req_after_ack", {31'd0, mem_req}, 32'd0);
    clear_inputs();
    mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("ifdone_low", {31'd0, IFDone}, 32'd0);
    check("mdone_low", {31'd0, MDone}, 32'd0);
    check("ifdata", IFData, v.exp_if);
    check("readdatam", ReadDataM, v.exp_rd);
    check("stallf_after", {31'd0, StallF}, 32'd0);
    check("stallm_after", {31'd0, StallM}, 32'd0);
    check("idle_after", {30'd0, dbg_state}, {30'd0, S_IDLE});
  endtask

  logic exp_own[4];
  int   n_grants;
  logic seen_if;

  initial begin
    rst = 1;
    clear_inputs();

    // reset state
    repeat (2) @(negedge clk);
    check("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_byte", {31'd0, mem_byte}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_dones", {30'd0, IFDone, MDone}, 32'd0);
    check("rst_ifdata", IFData, 32'd0);
    check("rst_readdatam", ReadDataM, 32'd0);
    rst = 0;

    // is_d we bsel addr wdata rdata waits exp_if exp_rd
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h00000100, 32'h0, 32'h00500093, 0, 32'h00500093, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h00002000, 32'hDEADBEEF, 32'h11111111, 3, 32'h00500093, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h00003000, 32'h0, 32'hCAFEF00D, 1, 32'h00500093, 32'hCAFEF00D};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h00000104, 32'h0, 32'h12345678, 2, 32'h12345678, 32'hCAFEF00D};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h00000040, 32'h00000005, 32'h22222222, 0, 32'h12345678, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h00000041, 32'h0, 32'h000000A5, 0, 32'h12345678, 32'h000000A5};

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // reset while BUSY_D, then a late ack
    @(negedge clk);
    MemReadM = 1; AddrM = 32'h00000500;
    @(negedge clk);
    check("busy_d_before_rst", {30'd0, dbg_state}, {30'd0, S_BUSY_D});
    #1 rst = 1;
    #1;
    check("async_rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    rst = 0; MemReadM = 0; AddrM = 0;
    mem_ack = 1; mem_rdata = 32'hBAD0BAD0;
    // ack held high while idle with no requests
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("late_ack_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
      check("late_ack_mem_req", {31'd0, mem_req}, 32'd0);
      check("late_ack_dones", {30'd0, IFDone, MDone}, 32'd0);
      check("late_ack_readdatam", ReadDataM, 32'd0);
      check("late_ack_ifdata", IFData, 32'd0);
    end
    mem_ack = 0;

    // simultaneous IF and data read requests from reset
`ifdef MEMARB_ROUND_ROBIN_EN
    exp_own = '{1'b1, 1'b0, 1'b1, 1'b0};
    n_grants = 4;
`else
    exp_own = '{1'b1, 1'b0, 1'b0, 1'b0};
    n_grants = 2;
`endif
    do_reset();
    IFReq = 1; IFAddr = 32'h00000200;
    MemReadM = 1; AddrM = 32'h00000300;
    seen_if = 0;
    for (int g = 0; g < n_grants; g++) begin
      @(negedge clk);
      check("tie_grant_state", {30'd0, dbg_state}, {30'd0, exp_own[g] ? S_BUSY_D : S_BUSY_IF});
      check("tie_mem_addr", mem_addr, exp_own[g] ? 32'h00000300 : 32'h00000200);
      if (!seen_if) check("tie_stallf_busy", {31'd0, StallF}, 32'd1);
      mem_ack = 1; mem_rdata = 32'h00001000 + g;
      @(negedge clk);
      check("tie_ifdone", {31'd0, IFDone}, {31'd0, ~exp_own[g]});
      check("tie_mdone", {31'd0, MDone}, {31'd0, exp_own[g]});
      if (!seen_if && exp_own[g]) check("tie_stallf_done", {31'd0, StallF}, 32'd1);
      if (!exp_own[g]) seen_if = 1;
      mem_ack = 0;
`ifndef MEMARB_ROUND_ROBIN_EN
      if (exp_own[g]) MemReadM = 0;
`endif
      if (g == n_grants - 1) begin
        IFReq = 0; MemReadM = 0;
      end
      @(negedge clk);
      check("tie_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
      if (!seen_if) check("tie_stallf_idle", {31'd0, StallF}, 32'd1);
    end
    check("tie_ifdata", IFData, 32'h00001000 + n_grants - 1);
    check("tie_readdatam", ReadDataM, 32'h00001000 + n_grants - 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
